matmul_result_streamer: RTL and testbench
=========================================

Name: matmul_result_streamer

Overview:
- Drains the result matrix C produced by the matmul calculator and serializes it onto a valid/ready element stream in row-major order.
- Sits downstream of the calculator's done indication. It is the reader-side counterpart of the path that writes A/B and pulses enable.
- Snapshots C on done, so the calculator may start the next operation while streaming is still in progress.

Parameters:
- DATA_WIDTH, 8, width of A/B elements.
- N, 4, rows of C (rows of A).
- K, 4, inner dimension (cols of A / rows of B); sets accumulator growth.
- M, 4, cols of C (cols of B).
- C_WIDTH (localparam), 2*DATA_WIDTH+$clog2(K) = 18, width of one C element.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- done_i  in  1  one-cycle pulse: matrix_c_i is valid this cycle.
- matrix_c_i  in  N*M*C_WIDTH  flattened C; element (r,c) at bits [(r*M+c)*C_WIDTH +: C_WIDTH].
- out_valid_o  out  1  out_data_o holds a valid element.
- out_ready_i  in  1  consumer accepts the element when out_valid_o && out_ready_i (a handshake).
- out_data_o  out  C_WIDTH  current element.
- out_row_o  out  $clog2(N)  row index of the current element.
- out_col_o  out  $clog2(M)  column index of the current element.
- out_last_o  out  1  current element is (N-1,M-1).
- busy_o  out  1  a snapshot is held and not yet fully streamed.
- drop_o  out  1  sticky: a done_i pulse was ignored.

Behaviour:
- Reset (async, any time, including mid-stream):
  - all outputs go to 0; snapshot buffer contents don't-care; row/col counters go to 0; state goes to IDLE.
  - The partially streamed matrix is discarded and no further elements are emitted.
- States: IDLE, STREAM.
- IDLE:
  - done_i=1 → capture matrix_c_i into the snapshot register at this edge, set row=col=0, go to STREAM.
  - out_valid_o=1 from the next cycle, so latency from done_i to the first valid is 1 cycle.
- STREAM:
  - out_valid_o=1 and busy_o=1.
  - out_data_o = snapshot element (row,col).
  - out_last_o = (row==N-1 && col==M-1).
- On a handshake:
  - col increments. When col==M-1 it wraps to 0 and row increments.
  - On the handshake of the last element, go to IDLE; out_valid_o and busy_o drop in the next cycle.
- Stall (valid && !ready): out_data_o, out_row_o, out_col_o and out_last_o hold stable. out_valid_o must not deassert.
- Throughput: one element per cycle while out_ready_i=1. A full matrix takes N*M handshake cycles.
- Back-to-back:
  - A done_i in the same cycle as the last-element handshake captures the new matrix, resets the counters and stays in STREAM.
  - There is no bubble: the next cycle presents element (0,0) of the new matrix.
- Any other done_i while in STREAM is ignored. The snapshot is unchanged, and drop_o is set to 1 and stays at 1 until rst.
- out_valid_o never depends combinationally on out_ready_i.
- All outputs are registered or derived from registered state only; there is no input-to-output combinational path.
- Widths: the element slice is taken verbatim with no sign handling. The consumer interprets C as unsigned C_WIDTH-bit values.

Decomposition:
- Shared package matmul_calc_pkg holds:
  - DATA_WIDTH, N, K, M, C_WIDTH;
  - typedef elemC (logic [C_WIDTH-1:0]);
  - typedef matC (flattened C, N*M*C_WIDTH bits);
  - typedef stream_state_e {IDLE, STREAM}.
- No sub-module: the snapshot register, counters and FSM live in one module.
- The element mux is a single indexed part-select.

Test Plan:
1. Basic stream, out_ready_i held at 1:
   - Stimulus: reset; done_i with C(r,c)=r*4+c.
   - Required: out_valid_o rises 1 cycle after done_i; data 0..15 on 16 consecutive cycles; row/col match; out_last_o only with data=15; busy_o=0 in the following cycle.
2. Backpressure, out_ready_i toggling 1,0,0,1,…:
   - Required: data, row and col hold during every stall; the sequence is still 0..15; out_valid_o never drops mid-stream.
3. Snapshot isolation:
   - Stimulus: after done_i, change matrix_c_i to all 0x3FFFF.
   - Required: the streamed values are still the captured 0..15.
4. Back-to-back:
   - Stimulus: second done_i (C(r,c)=100+r*4+c) on the same cycle as the handshake of element 15.
   - Required: the next cycle shows out_data_o=100 with row=0, col=0; no idle cycle; drop_o=0.
5. Drop:
   - Stimulus: done_i while streaming element 5.
   - Required: the stream continues 6..15 unchanged; drop_o=1 and stays at 1 until rst.
6. Reset mid-stream:
   - Stimulus: assert rst asynchronously (between clock edges) during element 7.
   - Required: out_valid_o, busy_o and drop_o go to 0 immediately; after release no output until the next done_i, which then streams from (0,0).

Source files
------------

// File: rtl/matmul_calc_pkg.sv
// Shared matmul types and dimensions used by the calculator and its result streamer.
`timescale 1ns/1ps
package matmul_calc_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int N          = 4;
  localparam int K          = 4;
  localparam int M          = 4;
  localparam int C_WIDTH    = 2*DATA_WIDTH + $clog2(K);
  localparam int ROW_W      = $clog2(N);
  localparam int COL_W      = $clog2(M);
  localparam int IDX_W      = $clog2(N*M);

  typedef logic [C_WIDTH-1:0]     elemC;
  typedef logic [N*M*C_WIDTH-1:0] matC;
  typedef enum logic {IDLE, STREAM} stream_state_e;
endpackage

// File: rtl/matmul_result_streamer.sv
// Snapshots the C matrix on done_i and emits it row-major on a valid/ready stream,
// allowing a new matrix to be captured on the final handshake without a bubble.
`timescale 1ns/1ps
module matmul_result_streamer
  import matmul_calc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_i,
  input  logic [N*M*C_WIDTH-1:0]     matrix_c_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [C_WIDTH-1:0]         out_data_o,
  output logic [ROW_W-1:0]           out_row_o,
  output logic [COL_W-1:0]           out_col_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic                       drop_o
);

  stream_state_e    r_state, w_state_nxt;
  matC              r_snap;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             r_drop, w_drop_nxt;
  logic             w_capture;
  logic             w_at_last;
  logic             w_streaming;
  logic [IDX_W-1:0] w_idx;
  elemC             w_elem;

  assign w_streaming = (r_state == STREAM);
  assign w_at_last   = (r_row == ROW_W'(N-1)) && (r_col == COL_W'(M-1));

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_drop_nxt  = r_drop;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (done_i) begin
          w_capture   = 1'b1;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (out_ready_i) begin
          if (w_at_last) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
            // A done arriving with the final handshake chains straight into the next matrix
            if (done_i) w_capture   = 1'b1;
            else        w_state_nxt = IDLE;
          end else if (r_col == COL_W'(M-1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
        if (done_i && !w_capture) w_drop_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_snap <= matrix_c_i;
  end

  assign w_idx  = IDX_W'(r_row) * IDX_W'(M) + IDX_W'(r_col);
  assign w_elem = r_snap[int'(w_idx)*C_WIDTH +: C_WIDTH];

  // Data is gated so that outputs read as zero whenever nothing is being streamed
  assign out_valid_o = w_streaming;
  assign busy_o      = w_streaming;
  assign out_data_o  = w_streaming ? w_elem : '0;
  assign out_row_o   = r_row;
  assign out_col_o   = r_col;
  assign out_last_o  = w_streaming && w_at_last;
  assign drop_o      = r_drop;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Directed bench for matmul_result_streamer: stream order, backpressure, snapshot, chaining, drop, reset.
`timescale 1ns/1ps
module tb_matmul_result_streamer;
  import matmul_calc_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   done_i;
  logic [N*M*C_WIDTH-1:0] matrix_c_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [C_WIDTH-1:0]     out_data_o;
  logic [ROW_W-1:0]       out_row_o;
  logic [COL_W-1:0]       out_col_o;
  logic                   out_last_o;
  logic                   busy_o;
  logic                   drop_o;

  int checks   = 0;
  int failures = 0;

  matmul_result_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .done_i      (done_i),
    .matrix_c_i  (matrix_c_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_row_o   (out_row_o),
    .out_col_o   (out_col_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .drop_o      (drop_o)
  );

  always #5 clk = ~clk;

  function automatic matC mk(input int base);
    matC m;
    m = '0;
    for (int i = 0; i < N*M; i++) m[i*C_WIDTH +: C_WIDTH] = C_WIDTH'(base + i);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one presented element: valid, data, row, col, last, busy.
  task automatic expect_elem(input string tag, input int exp_data, input int idx);
    checks++;
    if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL %s valid/busy idx=%0d got valid=%b busy=%b want 1/1", tag, idx, out_valid_o, busy_o);
    end
    checks++;
    if (out_data_o !== C_WIDTH'(exp_data)) begin
      failures++;
      $display("FAIL %s data idx=%0d got %0d want %0d", tag, idx, out_data_o, exp_data);
    end
    checks++;
    if (out_row_o !== ROW_W'(idx / M) || out_col_o !== COL_W'(idx % M)) begin
      failures++;
      $display("FAIL %s rowcol idx=%0d got (%0d,%0d) want (%0d,%0d)", tag, idx, out_row_o, out_col_o, idx / M, idx % M);
    end
    checks++;
    if (out_last_o !== (idx == N*M-1)) begin
      failures++;
      $display("FAIL %s last idx=%0d got %b want %b", tag, idx, out_last_o, (idx == N*M-1));
    end
  endtask

  task automatic expect_idle(input string tag);
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_last_o !== 1'b0) begin
      failures++;
      $display("FAIL %s idle got valid=%b busy=%b last=%b want 0/0/0", tag, out_valid_o, busy_o, out_last_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; done_i = 1'b0; out_ready_i = 1'b0; matrix_c_i = '0;
    tick(); tick();
    checks++;
    if ({out_valid_o, busy_o, drop_o, out_last_o} !== 4'b0 || out_data_o !== '0 || out_row_o !== '0 || out_col_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b b=%b d=%b l=%b data=%0d r=%0d c=%0d want all 0",
               out_valid_o, busy_o, drop_o, out_last_o, out_data_o, out_row_o, out_col_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    done_i = 1'b1; matrix_c_i = mk(0); out_ready_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_no_comb_valid got %b want 0", out_valid_o);
    end
    tick();
    done_i = 1'b0;
    for (int i = 0; i < N*M; i++) begin
      expect_elem("basic", i, i);
      tick();
    end
    expect_idle("basic_after");
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp = 0;
    int k = 0;
    done_i = 1'b1; matrix_c_i = mk(0); out_ready_i = 1'b0;
    tick();
    done_i = 1'b0;
    while (exp < N*M && k < 200) begin
      out_ready_i = pat[k % 4];
      expect_elem("bp", exp, exp);
      if (out_ready_i) exp++;
      k++;
      tick();
    end
    checks++;
    if (exp != N*M) begin
      failures++;
      $display("FAIL bp_timeout got %0d elements want %0d", exp, N*M);
    end
    out_ready_i = 1'b1;
    expect_idle("bp_after");
  endtask

  task automatic test_snapshot();
    done_i = 1'b1; matrix_c_i = mk(0); out_ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    for (int i = 0; i < N*M; i++) matrix_c_i[i*C_WIDTH +: C_WIDTH] = {C_WIDTH{1'b1}};
    for (int i = 0; i < N*M; i++) begin
      expect_elem("snap", i, i);
      tick();
    end
    expect_idle("snap_after");
  endtask

  task automatic test_back_to_back();
    done_i = 1'b1; matrix_c_i = mk(0); out_ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    for (int i = 0; i < N*M; i++) begin
      expect_elem("b2b_first", i, i);
      if (i == N*M-1) begin
        done_i = 1'b1; matrix_c_i = mk(100);
      end
      tick();
    end
    done_i = 1'b0;
    for (int i = 0; i < N*M; i++) begin
      expect_elem("b2b_second", 100 + i, i);
      if (i == 0) begin
        checks++;
        if (drop_o !== 1'b0) begin
          failures++;
          $display("FAIL b2b_drop got %b want 0", drop_o);
        end
      end
      tick();
    end
    expect_idle("b2b_after");
  endtask

  task automatic test_drop();
    done_i = 1'b1; matrix_c_i = mk(0); out_ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    for (int i = 0; i < N*M; i++) begin
      expect_elem("drop", i, i);
      if (i == 6) begin
        checks++;
        if (drop_o !== 1'b1) begin
          failures++;
          $display("FAIL drop_set got %b want 1", drop_o);
        end
      end
      if (i == 5) begin
        done_i = 1'b1; matrix_c_i = mk(200);
      end else begin
        done_i = 1'b0;
      end
      tick();
    end
    expect_idle("drop_after");
    tick(); tick();
    checks++;
    if (drop_o !== 1'b1) begin
      failures++;
      $display("FAIL drop_sticky got %b want 1", drop_o);
    end
  endtask

  task automatic test_reset_mid();
    done_i = 1'b1; matrix_c_i = mk(0); out_ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    expect_elem("rstmid_pre", 7, 7);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_o, busy_o, drop_o, out_last_o} !== 4'b0 || out_data_o !== '0) begin
      failures++;
      $display("FAIL rstmid_async got v=%b b=%b d=%b l=%b data=%0d want 0",
               out_valid_o, busy_o, drop_o, out_last_o, out_data_o);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("rstmid_quiet");
    end
    done_i = 1'b1; matrix_c_i = mk(50);
    tick();
    done_i = 1'b0;
    for (int i = 0; i < N*M; i++) begin
      expect_elem("rstmid_restart", 50 + i, i);
      tick();
    end
    expect_idle("rstmid_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
